ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
Upstream input stage for the game state machine. It receives raw PS/2 keyboard frames on the PS2_CLK/PS2_DATA pins, checks each frame, and decodes the scan-code stream into game commands. It outputs the 3-bit KEY_VALUE and a one-cycle KEY_VALID strobe that the game FSM consumes directly.

Parameters:
TIMEOUT_CYCLES, 100000, CLK cycles without a PS/2 falling edge before a partial frame is aborted (1 ms at 100 MHz).
SYNC_STAGES, 2, synchroniser depth on PS2_CLK and PS2_DATA; legal range 2..4.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
PS2_CLK  in  1  raw keyboard clock, asynchronous, idle high
PS2_DATA  in  1  raw keyboard data, asynchronous, idle high
KEY_VALUE  out  3  command code: 1 left, 2 up, 3 right, 4 down, 5 space; 0 only after reset
KEY_VALID  out  1  one-cycle strobe; KEY_VALUE is meaningful in the same cycle
FRAME_ERR  out  1  one-cycle strobe on parity error, stop-bit error or timeout

Behaviour:
- Reset: RESET is synchronous, active-high; clock is CLK.
  - Outputs: KEY_VALUE=0, KEY_VALID=0, FRAME_ERR=0.
  - Synchroniser flops load 1. Receiver goes to IDLE, decoder to BASE, bit counter 0, timeout counter 0.
  - Reset mid-frame discards the partial frame with no strobe.
- Input sync: SYNC_STAGES flops per pin, plus one extra PS2_CLK flop for edge detect. A sample event is a synced PS2_CLK 1->0 transition. Data is taken from the synced PS2_DATA in the same cycle.
- Receiver states:
  - IDLE: on a sample with data=0 (start bit), go to DATA with count=0. A sample with data=1 is ignored.
  - DATA: shift 8 bits, LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the bit; go to STOP.
  - STOP: the frame is good if the ones-count of 8 data bits plus parity is odd and stop=1. Good frame: byte strobe 1 cycle. Bad frame: FRAME_ERR. Either way return to IDLE.
- Timeout: the counter runs while the receiver is not in IDLE and clears on each sample event. Reaching TIMEOUT_CYCLES-1 aborts to IDLE and pulses FRAME_ERR. The count saturates and never wraps.
- Any FRAME_ERR also forces the decoder to BASE.
- Decoder FSM, advanced by each good byte:
  - BASE: E0 -> EXT; F0 -> BRK; 29 -> emit 5; other -> BASE, no emit.
  - EXT: 75 -> emit 2; 72 -> emit 4; 6B -> emit 1; 74 -> emit 3; F0 -> EXT_BRK; E0 -> EXT; other -> BASE. Every emit returns to BASE.
  - BRK: any byte -> BASE (break code, no emit).
  - EXT_BRK: any byte -> BASE (no emit).
- Latency: KEY_VALID rises exactly 1 CLK after the cycle that samples the stop bit. It is high for exactly 1 cycle.
- KEY_VALUE updates only together with KEY_VALID and holds its value otherwise.
- KEY_VALID and FRAME_ERR are never high in the same cycle.
- Unmapped keys produce no strobe.
- Back-to-back frames with no idle gap are accepted.

Optional Feature:
KEY_REPEAT_FILTER_EN
- Defined: a 5-bit held mask has one bit per command. A make code whose bit is already set is suppressed (no KEY_VALID). The matching break sequence clears the bit: F0 29 clears space; E0 F0 xx clears the arrow xx. FRAME_ERR or RESET clears the whole mask.
- Undefined: every make code, including keyboard typematic repeats, produces a KEY_VALID. No mask logic is built.

Decomposition:
- Package ps2_key_pkg:
  - scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_SPACE=29, SC_UP=75, SC_DOWN=72, SC_LEFT=6B, SC_RIGHT=74
  - command codes: KEY_LEFT=1, KEY_UP=2, KEY_RIGHT=3, KEY_DOWN=4, KEY_SPACE=5
  - receiver and decoder state encodings
- Sub-module ps2_frame_rx: synchroniser, edge detect, shifter, parity/stop check and timeout. It outputs RX_BYTE[7:0], RX_STROBE and RX_ERR.
- ps2_key_decoder instantiates ps2_frame_rx and holds the decoder FSM and the optional filter.

Test Plan:
- Frame byte 29 with correct parity=0 and stop=1 -> KEY_VALID for 1 cycle, KEY_VALUE=5, FRAME_ERR=0.
- Frames E0 then 75 -> exactly one KEY_VALID, KEY_VALUE=2. Repeat the test with 72, 6B and 74 -> values 4, 1, 3 respectively.
- Break sequences F0 29 and E0 F0 74 -> no KEY_VALID. A following 29 -> KEY_VALUE=5.
- Byte 29 sent with a wrong parity bit -> FRAME_ERR pulse, no KEY_VALID. A following good 29 -> KEY_VALUE=5.
- Stall PS2_CLK high after 4 data bits for TIMEOUT_CYCLES (set to 50 in the bench) -> FRAME_ERR pulse. A following full frame 29 decodes to 5.
- With KEY_REPEAT_FILTER_EN defined: 29, 29, 29 -> one KEY_VALID. Then F0 29 followed by 29 -> a second KEY_VALID. Without the macro: 29 ×3 -> three KEY_VALID.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared constants and state encodings for the PS/2 key decoder.
// Covers the scan codes, the game command codes and the FSM state types.
package ps2_key_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [2:0] KEY_NONE  = 3'd0;
    localparam logic [2:0] KEY_LEFT  = 3'd1;
    localparam logic [2:0] KEY_UP    = 3'd2;
    localparam logic [2:0] KEY_RIGHT = 3'd3;
    localparam logic [2:0] KEY_DOWN  = 3'd4;
    localparam logic [2:0] KEY_SPACE = 3'd5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        DEC_BASE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_e;

    // Arrow command for a byte that follows E0; KEY_NONE if unmapped.
    function automatic logic [2:0] ext_key(input logic [7:0] code);
        logic [2:0] key;
        case (code)
            SC_UP:    key = KEY_UP;
            SC_DOWN:  key = KEY_DOWN;
            SC_LEFT:  key = KEY_LEFT;
            SC_RIGHT: key = KEY_RIGHT;
            default:  key = KEY_NONE;
        endcase
        return key;
    endfunction

    // One held-mask bit per command (bit 0 = command 1); zero for KEY_NONE.
    function automatic logic [4:0] key_mask(input logic [2:0] key);
        logic [4:0] mask;
        case (key)
            KEY_LEFT:  mask = 5'b00001;
            KEY_UP:    mask = 5'b00010;
            KEY_RIGHT: mask = 5'b00100;
            KEY_DOWN:  mask = 5'b01000;
            KEY_SPACE: mask = 5'b10000;
            default:   mask = 5'b00000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge sampling, 11-bit frame
// shifter with odd-parity/stop check and an inter-edge timeout.
module ps2_frame_rx
    import ps2_key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] RX_BYTE,
    output logic       RX_STROBE,
    output logic       RX_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    rx_state_e              state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [CNT_W-1:0]       to_cnt_q, to_cnt_d;

    logic                   clk_s;
    logic                   data_s;
    logic                   sample;
    logic                   frame_ok;
    logic                   timeout_hit;

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign data_s   = data_sync_q[SYNC_STAGES-1];
    assign sample   = clk_prev_q & ~clk_s;
    assign frame_ok = (^{shift_q, parity_q}) & data_s;
    // A sample event always wins over an expiring timeout in the same cycle.
    assign timeout_hit = (state_q != RX_IDLE) && !sample && (to_cnt_q == TO_LAST);

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], PS2_DATA};
        clk_prev_d  = clk_s;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        to_cnt_d  = to_cnt_q;
        case (state_q)
            RX_IDLE: begin
                if (sample && !data_s) begin
                    state_d   = RX_DATA;
                    bit_cnt_d = '0;
                end
            end
            RX_DATA: begin
                if (sample) begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = RX_PARITY;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (sample) begin
                    parity_d = data_s;
                    state_d  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (sample) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (state_q == RX_IDLE || sample) begin
            to_cnt_d = '0;
        end else if (timeout_hit) begin
            to_cnt_d = '0;
            state_d  = RX_IDLE;
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_comb begin
        RX_BYTE   = shift_q;
        RX_STROBE = (state_q == RX_STOP) && sample && frame_ok;
        RX_ERR    = ((state_q == RX_STOP) && sample && !frame_ok) || timeout_hit;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to game-command decoder built on ps2_frame_rx.
// Optional typematic-repeat suppression is enabled by defining KEY_REPEAT_FILTER_EN.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [2:0] KEY_VALUE,
    output logic       KEY_VALID,
    output logic       FRAME_ERR
);

    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_err;

    dec_state_e dec_q, dec_d;
    logic       emit;
    logic [2:0] emit_key;
    logic       suppress;

    logic [2:0] key_value_q, key_value_d;
    logic       key_valid_q, key_valid_d;
    logic       frame_err_q, frame_err_d;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .CLK       (CLK),
        .RESET     (RESET),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .RX_BYTE   (rx_byte),
        .RX_STROBE (rx_strobe),
        .RX_ERR    (rx_err)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dec_q <= DEC_BASE;
        end else begin
            dec_q <= dec_d;
        end
    end

    always_comb begin
        dec_d = dec_q;
        if (rx_err) begin
            dec_d = DEC_BASE;
        end else if (rx_strobe) begin
            case (dec_q)
                DEC_BASE: begin
                    if (rx_byte == SC_EXT)      dec_d = DEC_EXT;
                    else if (rx_byte == SC_BRK) dec_d = DEC_BRK;
                    else                        dec_d = DEC_BASE;
                end
                DEC_EXT: begin
                    if (rx_byte == SC_BRK)      dec_d = DEC_EXT_BRK;
                    else if (rx_byte == SC_EXT) dec_d = DEC_EXT;
                    else                        dec_d = DEC_BASE;
                end
                default: dec_d = DEC_BASE;
            endcase
        end
    end

    always_comb begin
        emit     = 1'b0;
        emit_key = KEY_NONE;
        if (rx_strobe) begin
            case (dec_q)
                DEC_BASE: begin
                    if (rx_byte == SC_SPACE) begin
                        emit     = 1'b1;
                        emit_key = KEY_SPACE;
                    end
                end
                DEC_EXT: begin
                    emit_key = ext_key(rx_byte);
                    emit     = (emit_key != KEY_NONE);
                end
                default: ;
            endcase
        end
    end

`ifdef KEY_REPEAT_FILTER_EN
    logic [4:0] held_q, held_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            held_q <= '0;
        end else begin
            held_q <= held_d;
        end
    end

    // A make sets its bit; the break code that follows F0 (or E0 F0) clears it.
    always_comb begin
        held_d   = held_q;
        suppress = |(held_q & key_mask(emit_key));
        if (rx_err) begin
            held_d = '0;
        end else if (emit) begin
            held_d = held_q | key_mask(emit_key);
        end else if (rx_strobe && dec_q == DEC_BRK && rx_byte == SC_SPACE) begin
            held_d = held_q & ~key_mask(KEY_SPACE);
        end else if (rx_strobe && dec_q == DEC_EXT_BRK) begin
            held_d = held_q & ~key_mask(ext_key(rx_byte));
        end
    end
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        key_valid_d = emit && !suppress;
        key_value_d = key_valid_d ? emit_key : key_value_q;
        frame_err_d = rx_err;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_value_q <= KEY_NONE;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            key_value_q <= key_value_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign KEY_VALUE = key_value_q;
    assign KEY_VALID = key_valid_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames and checks strobes,
// command values, latency, timeout and the optional repeat filter.
module tb_ps2_key_decoder;
    import ps2_key_pkg::*;

    localparam int TO_CYCLES = 50;
    localparam int SYNC      = 2;
    localparam int HALF      = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic [2:0] KEY_VALUE;
    logic       KEY_VALID;
    logic       FRAME_ERR;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;
    int long_cnt = 0;
    int last_value = 0;
    logic prev_valid = 1'b0;
    int v0, e0, lat;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (TO_CYCLES),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .KEY_VALUE (KEY_VALUE),
        .KEY_VALID (KEY_VALID),
        .FRAME_ERR (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (KEY_VALID) begin
            valid_cnt  = valid_cnt + 1;
            last_value = int'(KEY_VALUE);
            if (prev_valid) long_cnt = long_cnt + 1;
        end
        if (FRAME_ERR) err_cnt = err_cnt + 1;
        if (KEY_VALID && FRAME_ERR) overlap_cnt = overlap_cnt + 1;
        prev_valid = KEY_VALID;
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One PS/2 bit: data set while clock high, then a low phase; lat reports
    // the first low-phase CLK at which KEY_VALID was seen (0 if none).
    task automatic send_bit(input logic b, output int lat_o);
        lat_o = 0;
        PS2_DATA = b;
        repeat (HALF) @(negedge CLK);
        PS2_CLK = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge CLK);
            if (KEY_VALID && lat_o == 0) lat_o = i;
        end
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, output int lat_o);
        int l;
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0, l);
        for (int i = 0; i < 8; i++) send_bit(b[i], l);
        send_bit(par, l);
        send_bit(1'b1, lat_o);
        PS2_DATA = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        int l;
        send_frame(b, 1'b0, l);
    endtask

    task automatic snap();
        v0 = valid_cnt;
        e0 = err_cnt;
    endtask

    task automatic settle();
        repeat (8) @(negedge CLK);
        #1;
    endtask

    task automatic expect_step(input string tag, input int nvalid, input int nerr, input int value);
        settle();
        check({tag, "_nvalid"}, valid_cnt - v0, nvalid);
        check({tag, "_nerr"}, err_cnt - e0, nerr);
        check({tag, "_value"}, last_value, value);
    endtask

    logic [7:0] arrow_sc [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    int         arrow_v  [4] = '{2, 4, 1, 3};

    initial begin
        int l;
        RESET    = 1'b1;
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        repeat (4) @(negedge CLK);
        check("rst_value", int'(KEY_VALUE), 0);
        check("rst_valid", int'(KEY_VALID), 0);
        check("rst_err", int'(FRAME_ERR), 0);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);

        // Space make, with latency from stop-bit falling edge.
        snap();
        send_frame(8'h29, 1'b0, lat);
        check("space_latency", lat, SYNC + 1);
        expect_step("space", 1, 0, 5);

        foreach (arrow_sc[k]) begin
            snap();
            send(8'hE0);
            send(arrow_sc[k]);
            expect_step($sformatf("arrow_%0d", arrow_v[k]), 1, 0, arrow_v[k]);
        end

        // Break sequences emit nothing; value holds at the last arrow.
        snap();
        send(8'hF0);
        send(8'h29);
        send(8'hE0);
        send(8'hF0);
        send(8'h74);
        expect_step("breaks", 0, 0, 3);
        check("hold_value", int'(KEY_VALUE), 3);
        snap();
        send(8'h29);
        expect_step("after_break", 1, 0, 5);

        // Parity error.
        snap();
        send_frame(8'h29, 1'b1, l);
        expect_step("bad_parity", 0, 1, 5);
        snap();
        send(8'h29);
        expect_step("after_parity", 1, 0, 5);

        // Timeout after 4 data bits.
        snap();
        send_bit(1'b0, l);
        for (int i = 0; i < 4; i++) send_bit(1'b1, l);
        PS2_DATA = 1'b1;
        repeat (TO_CYCLES + 10) @(negedge CLK);
        expect_step("timeout", 0, 1, 5);
        snap();
        send(8'h29);
        expect_step("after_timeout", 1, 0, 5);

        // Reset in mid-frame discards the partial frame.
        snap();
        send(8'hE0);
        send_bit(1'b0, l);
        for (int i = 0; i < 3; i++) send_bit(1'b0, l);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check("midrst_value", int'(KEY_VALUE), 0);
        RESET = 1'b0;
        PS2_DATA = 1'b1;
        settle();
        check("midrst_nvalid", valid_cnt - v0, 0);
        check("midrst_nerr", err_cnt - e0, 0);
        snap();
        send(8'h29);
        expect_step("after_midrst", 1, 0, 5);

        // Typematic repeats.
        send(8'hF0);
        send(8'h29);
        settle();
        snap();
        send(8'h29);
        send(8'h29);
        send(8'h29);
`ifdef KEY_REPEAT_FILTER_EN
        expect_step("repeat3", 1, 0, 5);
`else
        expect_step("repeat3", 3, 0, 5);
`endif
        snap();
        send(8'hF0);
        send(8'h29);
        send(8'h29);
        expect_step("rerelease", 1, 0, 5);

        check("valid_err_overlap", overlap_cnt, 0);
        check("valid_width", long_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
